// File: rtl/rpi_gpio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rpi_gpio_pkg: shared widths and event layout for the GPIO front end |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package rpi_gpio_pkg;

    localparam int GPIO_WIDTH = 28;
    localparam int TS_WIDTH   = 32;

    typedef struct packed {
        logic [TS_WIDTH-1:0]   ts;
        logic [GPIO_WIDTH-1:0] levels;
    } gpio_evt_t;

endpackage
`default_nettype wire

// File: rtl/gpio_evt_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gpio_evt_fifo: synchronous first-word fall-through event FIFO      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module gpio_evt_fifo #(
    parameter int DATA_W = 60,
    parameter int DEPTH  = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic              rd_en;
    logic              wr_en;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_en  = pop_i && !empty_o;
    assign wr_en  = push_i && (!full_o || rd_en);
    assign data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rpi_gpio_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rpi_gpio_input_conditioner: sync, debounce, edge detect and        |
// | timestamped change-event queue for the RPi GPIO lines               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rpi_gpio_input_conditioner
    import rpi_gpio_pkg::*;
#(
    parameter int WIDTH       = GPIO_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 500,
    parameter int TS_WIDTH    = rpi_gpio_pkg::TS_WIDTH,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [WIDTH-1:0]          gpio_in,
    output logic [WIDTH-1:0]          gpio_db,
    output logic [WIDTH-1:0]          gpio_rise,
    output logic [WIDTH-1:0]          gpio_fall,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [TS_WIDTH+WIDTH-1:0] evt_data,
    output logic                      evt_overflow,
    input  logic                      overflow_clr
);

    logic [WIDTH-1:0]    upd;
    logic [WIDTH-1:0]    db_nxt;
    logic [TS_WIDTH-1:0] ts_q;
    logic                ovf_q;
    logic                ovf_d;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   s;
            logic                   db_q;
            logic                   db_d;
            logic                   bit_upd;
            logic                   rise_q;
            logic                   fall_q;

            assign s = sync_q[SYNC_STAGES-1];

            if (DEB_CYCLES == 0) begin : g_nodeb
                always_comb begin
                    db_d    = s;
                    bit_upd = (s != db_q);
                end
            end else begin : g_deb
                localparam int             CW   = $clog2(DEB_CYCLES + 1);
                localparam logic [CW-1:0]  LAST = CW'(DEB_CYCLES - 1);
                logic [CW-1:0] cnt_q;
                logic [CW-1:0] cnt_d;

                always_comb begin
                    cnt_d   = cnt_q + 1'b1;
                    db_d    = db_q;
                    bit_upd = 1'b0;
                    if (s == db_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == LAST) begin
                        db_d    = s;
                        cnt_d   = '0;
                        bit_upd = 1'b1;
                    end
                end

                always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                    if (!sys_rst_n) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
            end

            // Edge pulses register on the same edge as db so they line up with it.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    sync_q <= '0;
                    db_q   <= 1'b0;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in[gi]};
                    db_q   <= db_d;
                    rise_q <= bit_upd & db_d;
                    fall_q <= bit_upd & ~db_d;
                end
            end

            assign upd[gi]       = bit_upd;
            assign db_nxt[gi]    = db_d;
            assign gpio_db[gi]   = db_q;
            assign gpio_rise[gi] = rise_q;
            assign gpio_fall[gi] = fall_q;
        end
    endgenerate

    // One event per cycle regardless of how many lines changed together.
    assign push      = |upd;
    assign evt_valid = !empty;
    assign pop       = evt_valid && evt_ready;

    always_comb begin
        ovf_d = ovf_q;
        if (overflow_clr) begin
            ovf_d = 1'b0;
        end
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ts_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            ts_q  <= ts_q + 1'b1;
            ovf_q <= ovf_d;
        end
    end

    assign evt_overflow = ovf_q;

    gpio_evt_fifo #(
        .DATA_W (TS_WIDTH + WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push_i    (push),
        .pop_i     (pop),
        .data_i    ({ts_q, db_nxt}),
        .data_o    (evt_data),
        .full_o    (full),
        .empty_o   (empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_rpi_gpio_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rpi_gpio_input_conditioner: directed self-checking bench        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_rpi_gpio_input_conditioner;
    import rpi_gpio_pkg::*;

    localparam int W  = 28;
    localparam int TW = 32;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [W-1:0]  gpio_in = '0;
    logic [W-1:0]  gpio_db;
    logic [W-1:0]  gpio_rise;
    logic [W-1:0]  gpio_fall;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [TW+W-1:0] evt_data;
    logic          evt_overflow;
    logic          overflow_clr = 1'b0;
    gpio_evt_t     evt_s;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [31:0]   cyc = '0;

    rpi_gpio_input_conditioner #(
        .WIDTH       (W),
        .SYNC_STAGES (2),
        .DEB_CYCLES  (4),
        .TS_WIDTH    (TW),
        .FIFO_DEPTH  (8)
    ) u_dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .gpio_in      (gpio_in),
        .gpio_db      (gpio_db),
        .gpio_rise    (gpio_rise),
        .gpio_fall    (gpio_fall),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_data     (evt_data),
        .evt_overflow (evt_overflow),
        .overflow_clr (overflow_clr)
    );

    assign evt_s = evt_data;

    always #5 sys_clk = ~sys_clk;

    // Independent edge count since reset release; equals the expected timestamp.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cyc <= '0;
        else            cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic pop_evt();
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_ts [9];
        logic [W-1:0] act;
        logic         vseen;
        logic [W-1:0] first_lv;
        logic [W-1:0] last_lv;
        logic [31:0]  last_ts;
        int           n;

        // 1. Reset with all lines high
        gpio_in = '1;
        tick(3);
        chk("rst_db",    gpio_db,      0);
        chk("rst_rise",  gpio_rise,    0);
        chk("rst_fall",  gpio_fall,    0);
        chk("rst_valid", evt_valid,    0);
        chk("rst_ovf",   evt_overflow, 0);
        chk("rst_data",  evt_data,     0);
        sys_rst_n = 1'b1;
        tick(5);
        chk("rst_db_e5", gpio_db, 0);
        tick(1);
        chk("rst_db_e6",    gpio_db,      28'hFFFFFFF);
        chk("rst_rise_e6",  gpio_rise,    28'hFFFFFFF);
        chk("rst_valid_e6", evt_valid,    1);
        chk("rst_evt_ts",   evt_s.ts,     32'd5);
        chk("rst_evt_lv",   evt_s.levels, 28'hFFFFFFF);
        tick(1);
        chk("rst_rise_1cyc", gpio_rise, 0);
        pop_evt();
        chk("rst_one_evt", evt_valid, 0);

        // Queue a fall event, then reset mid-operation: it must be discarded
        gpio_in = '0;
        tick(6);
        chk("fall_all", gpio_fall, 28'hFFFFFFF);
        chk("fall_evt_valid", evt_valid, 1);
        sys_rst_n = 1'b0;
        tick(2);
        chk("midrst_valid", evt_valid, 0);
        sys_rst_n = 1'b1;
        tick(10);
        chk("midrst_valid_after", evt_valid, 0);

        // 2. Clean edge on bit 3
        gpio_in[3] = 1'b1;
        exp_ts[0] = cyc + 5;
        tick(5);
        chk("b3_db_e5", gpio_db, 0);
        tick(1);
        chk("b3_db_e6",   gpio_db,      28'h0000008);
        chk("b3_rise",    gpio_rise,    28'h0000008);
        chk("b3_valid",   evt_valid,    1);
        chk("b3_evt_ts",  evt_s.ts,     exp_ts[0]);
        chk("b3_evt_lv",  evt_s.levels, 28'h0000008);
        tick(1);
        chk("b3_rise_1cyc", gpio_rise, 0);
        pop_evt();
        gpio_in[3] = 1'b0;
        tick(6);
        chk("b3_fall", gpio_fall, 28'h0000008);
        chk("b3_fall_lv", evt_s.levels, 0);
        pop_evt();
        chk("b3_drained", evt_valid, 0);

        // 3. Glitch on bit 5, 3 cycles wide
        act = '0;
        vseen = 1'b0;
        gpio_in[5] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) gpio_in[5] = 1'b0;
            tick(1);
            act   = act | gpio_db | gpio_rise | gpio_fall;
            vseen = vseen | evt_valid;
        end
        chk("glitch_activity", act, 0);
        chk("glitch_valid", vseen, 0);

        // 4. Simultaneous rise on bits 0 and 27
        gpio_in = 28'h8000001;
        tick(6);
        chk("sim_db",    gpio_db,      28'h8000001);
        chk("sim_rise",  gpio_rise,    28'h8000001);
        chk("sim_valid", evt_valid,    1);
        chk("sim_lv",    evt_s.levels, 28'h8000001);
        pop_evt();
        chk("sim_single", evt_valid, 0);
        gpio_in = '0;
        tick(6);
        pop_evt();
        chk("sim_fall_single", evt_valid, 0);

        // 5. Overflow: 9 separated changes on bit 1 with no reads
        for (int k = 0; k < 9; k++) begin
            gpio_in[1] = (k % 2 == 0);
            exp_ts[k] = cyc + 5;
            tick(8);
        end
        chk("ovf_flag", evt_overflow, 1);
        chk("ovf_valid", evt_valid, 1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovf_ts%0d", k), evt_s.ts, exp_ts[k]);
            chk($sformatf("ovf_lv%0d", k), evt_s.levels, (k % 2 == 0) ? 28'h2 : 28'h0);
            pop_evt();
        end
        chk("ovf_drained", evt_valid, 0);
        chk("ovf_sticky", evt_overflow, 1);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        chk("ovf_cleared", evt_overflow, 0);

        // 6. Full FIFO with a pop in the same cycle as a new event
        for (int k = 0; k < 8; k++) begin
            gpio_in[1] = (k % 2 == 1);
            tick(8);
        end
        chk("full_no_ovf", evt_overflow, 0);
        gpio_in[1] = 1'b0;
        last_ts = cyc + 5;
        tick(5);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("fullpop_ovf", evt_overflow, 0);
        n = 0;
        first_lv = '1;
        last_lv = '1;
        for (int i = 0; i < 12; i++) begin
            if (evt_valid) begin
                if (n == 0) first_lv = evt_s.levels;
                last_lv = evt_s.levels;
                if (n == 7) chk("fullpop_last_ts", evt_s.ts, last_ts);
                n++;
                pop_evt();
            end
        end
        chk("fullpop_count", n, 8);
        chk("fullpop_first_lv", first_lv, 28'h2);
        chk("fullpop_last_lv", last_lv, 28'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
